// File: rtl/icache_pkg.sv
// Shared types and derived address-field widths for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int line_words);
        return addr_w - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_tag_ram.sv
// Tag array and valid vector with combinational hit compare; flush clears every valid bit.
module icache_tag_ram
    import icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int TAG_W = 21
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [calc_idx_w(LINES)-1:0]  lk_idx_i,
    input  logic [TAG_W-1:0]              lk_tag_i,
    output logic                          hit_o,
    input  logic                          wr_en_i,
    input  logic [calc_idx_w(LINES)-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]              wr_tag_i
);

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q, valid_d;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    // Flush wins over a simultaneous line install.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign hit_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);

endmodule

// File: rtl/instr_cache_dm.sv
// Direct-mapped instruction cache: single-cycle hits, stalling burst refill on a miss.
module instr_cache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 32,
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_valid_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int OFF_W = calc_off_w(LINE_WORDS);
    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES, LINE_WORDS);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   miss_addr_q;
    logic [OFF_W-1:0]    beat_q;
    logic                flush_pend_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [31:0]         hit_cnt_q, miss_cnt_q;
    logic [DATA_W-1:0]   data_q [LINES*LINE_WORDS];

    logic [OFF_W-1:0]    req_off, miss_off;
    logic [IDX_W-1:0]    req_idx, miss_idx;
    logic [TAG_W-1:0]    req_tag, miss_tag;
    logic                tag_hit, accept, hit, miss, beat, last_beat, install;

    assign req_off  = addr_i[OFF_W-1:0];
    assign req_idx  = addr_i[OFF_W +: IDX_W];
    assign req_tag  = addr_i[ADDR_W-1 -: TAG_W];
    assign miss_off = miss_addr_q[OFF_W-1:0];
    assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];

    assign accept    = req_valid_i && ready_o;
    assign hit       = accept && tag_hit;
    assign miss      = accept && !tag_hit;
    assign beat      = (state_q == S_REFILL) && mem_valid_i;
    assign last_beat = beat && (beat_q == '1);
    // A flush seen at any point of the refill keeps the new line invalid.
    assign install   = last_beat && !flush_pend_q && !flush_i;

    icache_tag_ram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tag_ram (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .lk_idx_i (req_idx),
        .lk_tag_i (req_tag),
        .hit_o    (tag_hit),
        .wr_en_i  (install),
        .wr_idx_i (miss_idx),
        .wr_tag_i (miss_tag)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (miss) state_d = S_REFILL;
            S_REFILL: if (last_beat) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == S_IDLE) && !flush_i;
        mem_req_o  = (state_q == S_REFILL);
        mem_addr_o = '0;
        if (state_q == S_REFILL) begin
            mem_addr_o = {miss_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (beat) beat_q <= beat_q + 1'b1;
            if (miss) flush_pend_q <= 1'b0;
            else if ((state_q == S_REFILL) && flush_i) flush_pend_q <= 1'b1;
            rsp_valid_q <= hit || last_beat;
            // The requested word is captured as it streams past during refill.
            if (hit) rsp_data_q <= data_q[{req_idx, req_off}];
            else if (beat && (beat_q == miss_off)) rsp_data_q <= mem_data_i;
            if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (miss) miss_addr_q <= addr_i;
        if (beat) data_q[{miss_idx, beat_q}] <= mem_data_i;
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_instr_cache_dm.sv
// Randomized and directed bench for instr_cache_dm against a line-presence cache model.
module tb_instr_cache_dm;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [28:0] addr = '0;
    logic        ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        flush = 1'b0;
    logic        mem_req_o;
    logic [28:0] mem_addr_o;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    instr_cache_dm dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .addr_i      (addr),
        .ready_o     (ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .flush_i     (flush),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_valid_i (mem_valid),
        .mem_data_i  (mem_data),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle, written by the stimulus thread.
    bit          chk_en = 1'b0;
    logic        e_ready, e_rsp_valid, e_mem_req;
    logic [31:0] e_rsp_data, e_hits, e_misses;
    logic [28:0] e_mem_addr;

    typedef struct { int sel; logic [31:0] val; } pin_t;
    pin_t pins[$];

    int errors = 0;
    int checks = 0;

    // Behavioural model state: which line number each index holds (-1 = none).
    int          mline [LINES];
    logic [31:0] m_hits, m_misses;
    bit          pend_valid;
    logic [31:0] pend_data;
    longint      pend_pin;
    logic [31:0] img [int];

    function automatic logic [31:0] memw(input logic [28:0] a);
        if (img.exists(int'(a))) return img[int'(a)];
        return 32'(a) * 32'h9E3779B1 + 32'h1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready_o), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp_valid));
            if (e_rsp_valid) chk("rsp_data", rsp_data_o, e_rsp_data);
            chk("mem_req", 32'(mem_req_o), 32'(e_mem_req));
            if (e_mem_req) chk("mem_addr", 32'(mem_addr_o), 32'(e_mem_addr));
            chk("hit_cnt", hit_cnt_o, e_hits);
            chk("miss_cnt", miss_cnt_o, e_misses);
            while (pins.size() > 0) begin
                pin_t p;
                p = pins.pop_front();
                case (p.sel)
                    0: chk("pin_rsp_data", rsp_data_o, p.val);
                    1: chk("pin_mem_addr", 32'(mem_addr_o), p.val);
                    2: chk("pin_hit_cnt", hit_cnt_o, p.val);
                    3: chk("pin_miss_cnt", miss_cnt_o, p.val);
                    default: chk("pin_ready", 32'(ready_o), p.val);
                endcase
            end
        end
    end

    task automatic pin(input int sel, input logic [31:0] val);
        pin_t p;
        p.sel = sel;
        p.val = val;
        pins.push_back(p);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Default inputs and expectations for a cycle; consumes any hit response due now.
    task automatic set_common();
        chk_en      = 1'b1;
        e_hits      = m_hits;
        e_misses    = m_misses;
        e_rsp_valid = pend_valid;
        e_rsp_data  = pend_data;
        if (pend_valid && pend_pin >= 0) pin(0, 32'(pend_pin));
        pend_valid  = 1'b0;
        pend_pin    = -1;
        e_ready     = 1'b1;
        e_mem_req   = 1'b0;
        e_mem_addr  = '0;
        req_valid   = 1'b0;
        flush       = 1'b0;
        mem_valid   = 1'b0;
        mem_data    = $urandom;
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) mline[i] = -1;
    endtask

    task automatic do_reset();
        next_cycle();
        set_common();
        rst_n = 1'b0;
        model_flush();
        m_hits = 0;
        m_misses = 0;
        e_hits = 0;
        e_misses = 0;
        e_rsp_valid = 1'b0;
        pin(0, 32'h0);
        pin(1, 32'h0);
        next_cycle();
        set_common();
        rst_n = 1'b1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        set_common();
        mem_valid = 1'($urandom);
    endtask

    task automatic refill_cycle(input logic [28:0] line);
        next_cycle();
        set_common();
        e_ready    = 1'b0;
        e_mem_req  = 1'b1;
        e_mem_addr = line;
        req_valid  = 1'($urandom);
        addr       = 29'($urandom);
    endtask

    task automatic fetch(input logic [28:0] a, input int flush_beat = -1,
                         input int gap_after = -1, input int gap_len = 0,
                         input int reset_after = -1, input bit flush_idle = 1'b0,
                         input bit rand_gaps = 1'b0, input longint pin_word = -1,
                         input longint pin_line = -1);
        int          idx;
        logic [28:0] line;
        bit          blocked;
        idx  = int'(a[7:2]);
        line = {a[28:2], 2'b00};
        next_cycle();
        set_common();
        req_valid = 1'b1;
        addr      = a;
        if (flush_idle) begin
            flush   = 1'b1;
            e_ready = 1'b0;
            pin(4, 32'h0);
            model_flush();
            return;
        end
        if (mline[idx] == int'(a >> 2)) begin
            m_hits++;
            pend_valid = 1'b1;
            pend_data  = memw(a);
            pend_pin   = pin_word;
            return;
        end
        m_misses++;
        blocked = 1'b0;
        for (int b = 0; b < 4; b++) begin
            int n;
            n = (gap_after >= 0 && b == gap_after + 1) ? gap_len : 0;
            if (rand_gaps) n += $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                refill_cycle(line);
                mem_valid = 1'b0;
            end
            refill_cycle(line);
            mem_valid = 1'b1;
            mem_data  = memw(line + 29'(b));
            if (b == 0 && pin_line >= 0) pin(1, 32'(pin_line));
            if (b == flush_beat) begin
                flush = 1'b1;
                model_flush();
                blocked = 1'b1;
            end
            if (b == reset_after) begin
                do_reset();
                return;
            end
        end
        next_cycle();
        set_common();
        e_ready     = 1'b0;
        e_rsp_valid = 1'b1;
        e_rsp_data  = memw(a);
        if (pin_word >= 0) pin(0, 32'(pin_word));
        req_valid   = 1'($urandom);
        addr        = 29'($urandom);
        mem_valid   = 1'($urandom);
        if (!blocked) mline[idx] = int'(a >> 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_flush();
        m_hits = 0;
        m_misses = 0;
        pend_valid = 1'b0;
        pend_data = '0;
        pend_pin = -1;
        for (int i = 0; i < 4; i++) begin
            img[32'h1C + i] = 32'hA0 + 32'(i);
            img[32'h80 + i] = 32'hB0 + 32'(i);
            img[32'hC0 + i] = 32'hC0DE0000 + 32'(i);
        end

        // Cold miss, then back-to-back hits on the same line
        do_reset();
        fetch(29'h1C, .pin_word(32'hA0), .pin_line(32'h1C));
        fetch(29'h1D, .pin_word(32'hA1));
        fetch(29'h1E, .pin_word(32'hA2));
        fetch(29'h1F, .pin_word(32'hA3));
        idle_cycle();
        pin(2, 32'd3);
        pin(3, 32'd1);

        // Conflict eviction on index 0
        do_reset();
        fetch(29'h000);
        fetch(29'h100, .pin_line(32'h100));
        fetch(29'h000, .pin_line(32'h000));
        idle_cycle();
        pin(3, 32'd3);

        // Flush in IDLE blocks the request and invalidates the line
        do_reset();
        fetch(29'h40);
        fetch(29'h40, .flush_idle(1'b1));
        fetch(29'h40, .pin_line(32'h40));
        idle_cycle();
        pin(3, 32'd2);
        pin(2, 32'd0);

        // Flush during refill: word delivered, line left invalid
        do_reset();
        fetch(29'h80, .flush_beat(2), .pin_word(32'hB0));
        fetch(29'h80, .pin_line(32'h80));
        idle_cycle();
        pin(3, 32'd2);

        // Memory gaps between beats 1 and 2
        do_reset();
        fetch(29'hC2, .gap_after(1), .gap_len(3), .pin_word(32'hC0DE0002));
        fetch(29'hC3, .pin_word(32'hC0DE0003));
        fetch(29'hC0, .pin_word(32'hC0DE0000));
        idle_cycle();
        pin(2, 32'd2);
        pin(3, 32'd1);

        // Reset mid-refill leaves the partial line invalid
        do_reset();
        fetch(29'h1C0, .reset_after(1));
        fetch(29'h1C0, .pin_line(32'h1C0));
        idle_cycle();
        pin(3, 32'd1);

        // Randomized traffic over a small address space to mix hits and conflicts
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [28:0] a;
            r = $urandom_range(0, 99);
            a = 29'({$urandom_range(0, 3), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))});
            if (r < 10) idle_cycle();
            else if (r < 16) fetch(a, .flush_idle(1'b1));
            else if (r < 24) fetch(a, .flush_beat($urandom_range(0, 3)), .rand_gaps(1'b1));
            else fetch(a, .rand_gaps($urandom_range(0, 2) == 0));
        end

        idle_cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_cache_dm.md
# instr_cache_dm

Parametrised, direct-mapped instruction cache with line refill from a word-wide backing memory, valid-bit tracking, whole-cache flush and hit/miss counters. It sits between the fetch stage and the instruction memory and replaces the flat preloaded instruction array. Hits return one word per cycle at full throughput; misses stall the fetch stage while a line is burst-filled.

## Interface
- `ADDR_W`, 29: word-address width.
- `DATA_W`, 32: instruction word width.
- `LINES`, 64: number of cache lines (power of 2, ≥2).
- `LINE_WORDS`, 4: words per line (power of 2, ≥2).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `req_valid_i`  in  1  fetch request.
- `addr_i`  in  ADDR_W  word address of the fetch.
- `ready_o`  out  1  request accepted this cycle when high together with `req_valid_i`.
- `rsp_valid_o`  out  1  `rsp_data_o` is valid this cycle.
- `rsp_data_o`  out  DATA_W  fetched instruction word.
- `flush_i`  in  1  single-cycle pulse that invalidates all lines (fence.i).
- `mem_req_o`  out  1  line refill request.
- `mem_addr_o`  out  ADDR_W  line-aligned word address (low log2(LINE_WORDS) bits are 0).
- `mem_valid_i`  in  1  refill beat valid.
- `mem_data_i`  in  DATA_W  refill beat data.
- `hit_cnt_o`, `miss_cnt_o`  out  32 each  wrapping counters of accepted requests.

## Operation
- Address split: offset = low OFF_W = log2(LINE_WORDS) bits; index = next IDX_W = log2(LINES) bits; tag = remaining ADDR_W−OFF_W−IDX_W bits.
- Storage: data array LINES×LINE_WORDS×DATA_W, tag array LINES×TAG_W, valid vector LINES. Only the valid vector is reset (to all 0).
- States: IDLE, REFILL, RESP.
- IDLE: `ready_o`=1 unless `flush_i`=1. On an accepted request, a hit (valid[idx] and tag match) registers the word, sets `rsp_valid_o` the next cycle and increments `hit_cnt_o`. A miss latches the address, increments `miss_cnt_o`, and moves to REFILL.
- REFILL: `ready_o`=0. `mem_req_o`=1 and `mem_addr_o` = latched line address, both held stable until the last beat. Beats arrive in offset order 0..LINE_WORDS−1. Each cycle with `mem_valid_i`=1 writes one word and increments the beat counter; gaps are allowed. On the last beat, write the tag, set valid, and go to RESP.
- RESP: drive the requested word on `rsp_data_o` with `rsp_valid_o`=1 for one cycle. `ready_o`=0. Next state is IDLE.
- `mem_valid_i` outside REFILL is ignored.
- `flush_i`: clears the valid vector in that cycle.
  - In IDLE the flush has priority: `ready_o`=0 and no request is accepted.
  - During REFILL the refill completes and the word is delivered, but the line stays invalid. A flush pending for that refill blocks the final valid-set.
  - Counters are unaffected.
- Counters wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - `rsp_valid_o`=0, `rsp_data_o`=0, `mem_req_o`=0, `mem_addr_o`=0.
  - Counters 0, beat counter 0, state IDLE (so `ready_o`=1), valid vector all 0.
- Hit latency: 1 cycle from acceptance to `rsp_valid_o`. Back-to-back hits give 1 word per cycle.
- Miss latency, with no memory gaps: acceptance cycle; LINE_WORDS REFILL cycles (`mem_req_o` high from the cycle after acceptance); 1 RESP cycle. That is LINE_WORDS+2 cycles to `rsp_valid_o`.
- Reset asserted mid-refill: `mem_req_o` drops immediately (asynchronous). The partial line stays invalid.

## Structure
- Package `icache_pkg`: the derived widths OFF_W, IDX_W and TAG_W as functions of the parameters, plus the state enum (IDLE/REFILL/RESP).
- Sub-module `icache_tag_ram`: the tag array plus valid vector, with the combinational hit compare and the flush-clear port. Data array and FSM stay in the top.

## Test plan
All scenarios use the default parameters.
- **Cold miss, then hits.** Reset, request 0x1C. Expect `mem_addr_o`=0x1C; feed beats 0xA0,0xA1,0xA2,0xA3. Expect `rsp_data_o`=0xA0 at cycle 6. Then request 0x1D,0x1E,0x1F back-to-back. Expect 0xA1,0xA2,0xA3 on consecutive cycles, `hit_cnt_o`=3, `miss_cnt_o`=1.
- **Conflict eviction.** Fill 0x000, then request 0x100 (same index 0, different tag). Expect a miss with `mem_addr_o`=0x100. A re-request of 0x000 misses again; `miss_cnt_o`=3.
- **Flush in IDLE.** Fill 0x40, then pulse `flush_i` together with a request for 0x40. Expect `ready_o`=0 that cycle. The next request for 0x40 misses and refills.
- **Flush mid-refill.** Request 0x80; pulse `flush_i` after 2 beats. Expect the refill to complete, RESP to return beat 0, and a later request for 0x80 to miss.
- **Memory gaps.** Deassert `mem_valid_i` for 3 cycles between beats 1 and 2. Expect the beat counter and `mem_addr_o` to hold, and correct words to land at offsets 2 and 3.
- **Reset mid-refill.** Pull `rst_ni` low after beat 1. Expect all outputs at reset values within the same cycle. After release, a request for the same address misses.
